// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, source-select and reset-state definitions
package cpu_pkg;

  // Instruction classes, identified from the top nibble of the opcode.
  typedef enum logic [2:0] {
    OP_LOAD,
    OP_MOV,
    OP_ALU,
    OP_JMP,
    OP_JNZ
  } opcode_e;

  // Power-up sequencing states for the program sequencer's reset.
  typedef enum logic [1:0] {
    ST_HOLD,
    ST_ARM,
    ST_RUN
  } rst_state_e;

  // MOV r0,r0: decodes to no register load and no ALU activity.
  localparam logic [7:0] NOP = 8'h80;

  // Data-bus source codes beyond the eight registers.
  localparam logic [3:0] SRC_IMM = 4'd8;
  localparam logic [3:0] SRC_ALU = 4'd9;

  // Classify an instruction from its upper nibble.
  function automatic opcode_e decode_op(input logic [3:0] hi);
    opcode_e op;
    if (!hi[3])      op = OP_LOAD;
    else if (!hi[2]) op = OP_MOV;
    else if (!hi[1]) op = OP_ALU;
    else if (!hi[0]) op = OP_JMP;
    else             op = OP_JNZ;
    return op;
  endfunction

endpackage

// File: rtl/instruction_decoder_if.sv
// rtl/instruction_decoder_if.sv - fetch/decode signal bundle between decoder and datapath
interface instruction_decoder_if;
  logic [7:0] pm_data;
  logic       alu_zero;
  logic       sync_reset;
  logic       jmp;
  logic       jmp_nz;
  logic [3:0] jmp_addr;
  logic       dont_jmp;
  logic [7:0] ir;
  logic [7:0] reg_en;
  logic [3:0] src_sel;
  logic [3:0] imm;
  logic [2:0] alu_fn;
  logic       alu_en;

  // Decoder side: consumes the fetched word and ALU status, drives control.
  modport master (
    input  pm_data, alu_zero,
    output sync_reset, jmp, jmp_nz, jmp_addr, dont_jmp,
           ir, reg_en, src_sel, imm, alu_fn, alu_en
  );

  // Datapath / sequencer side.
  modport slave (
    output pm_data, alu_zero,
    input  sync_reset, jmp, jmp_nz, jmp_addr, dont_jmp,
           ir, reg_en, src_sel, imm, alu_fn, alu_en
  );
endinterface

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - HOLD/ARM/RUN sequencer producing the synchronous reset pulse
module reset_sequencer (
  input  logic clk,
  input  logic reset,
  output logic sync_reset
);
  import cpu_pkg::*;

  rst_state_e state_q;
  rst_state_e state_d;

  // State register; the async reset lands in HOLD immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_HOLD;
    else       state_q <= state_d;
  end

  // Advance one state per clock and stay in RUN; sync_reset is held until RUN.
  always_comb begin
    state_d    = state_q;
    sync_reset = 1'b1;
    case (state_q)
      ST_HOLD: state_d = ST_ARM;
      ST_ARM:  state_d = ST_RUN;
      ST_RUN: begin
        state_d    = ST_RUN;
        sync_reset = 1'b0;
      end
      default: state_d = ST_HOLD;
    endcase
  end

endmodule

// File: rtl/instruction_decoder.sv
// rtl/instruction_decoder.sv - fetch-stage jump decode, instruction register and execute decode
module instruction_decoder (
  input  logic                   clk,
  input  logic                   reset,
  instruction_decoder_if.master  bus
);
  import cpu_pkg::*;

  logic       sync_reset;
  logic [7:0] ir_q;
  logic       zero_q;
  logic [7:0] reg_en_d;
  logic [3:0] src_sel_d;
  logic       alu_en_d;
  logic       jmp_d;
  logic       jmp_nz_d;

  reset_sequencer u_reset_sequencer (
    .clk        (clk),
    .reset      (reset),
    .sync_reset (sync_reset)
  );

  // Jumps are taken at fetch, straight from the program memory word, and are
  // suppressed while the sequencer is still being held in reset.
  always_comb begin
    jmp_d    = 1'b0;
    jmp_nz_d = 1'b0;
    if (!sync_reset) begin
      jmp_d    = (bus.pm_data[7:4] == 4'hE);
      jmp_nz_d = (bus.pm_data[7:4] == 4'hF);
    end
  end

  // Instruction register: NOP while held, otherwise the fetched word each cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           ir_q <= NOP;
    else if (sync_reset) ir_q <= NOP;
    else                 ir_q <= bus.pm_data;
  end

  // Execute decode of the instruction in ir; jumps decode to no activity here.
  always_comb begin
    reg_en_d  = 8'h00;
    src_sel_d = 4'd0;
    alu_en_d  = 1'b0;
    case (decode_op(ir_q[7:4]))
      OP_LOAD: begin
        reg_en_d  = 8'b1 << ir_q[6:4];
        src_sel_d = SRC_IMM;
      end
      OP_MOV: begin
        if (ir_q[5:3] != ir_q[2:0]) begin
          reg_en_d  = 8'b1 << ir_q[5:3];
          src_sel_d = {1'b0, ir_q[2:0]};
        end
      end
      OP_ALU: begin
        alu_en_d  = 1'b1;
        src_sel_d = SRC_ALU;
      end
      default: ;
    endcase
  end

  // Zero flag captures the ALU result status at the end of each ALU cycle.
  // A JNZ fetched during that same cycle therefore sees the previous flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         zero_q <= 1'b0;
    else if (alu_en_d) zero_q <= bus.alu_zero;
  end

  assign bus.sync_reset = sync_reset;
  assign bus.jmp        = jmp_d;
  assign bus.jmp_nz     = jmp_nz_d;
  assign bus.jmp_addr   = bus.pm_data[3:0];
  assign bus.dont_jmp   = zero_q;
  assign bus.ir         = ir_q;
  assign bus.reg_en     = reg_en_d;
  assign bus.src_sel    = src_sel_d;
  assign bus.imm        = ir_q[3:0];
  assign bus.alu_fn     = ir_q[2:0];
  assign bus.alu_en     = alu_en_d;

endmodule

// File: tb/tb_instruction_decoder.sv
// tb/tb_instruction_decoder.sv - self-checking bench for instruction_decoder
module tb_instruction_decoder;

  logic clk = 1'b0;
  logic reset = 1'b0;

  instruction_decoder_if bus();

  instruction_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state: instruction in execution, zero flag, edges since reset release.
  logic [7:0] m_ir;
  logic       m_flag;
  int         m_edges;

  typedef struct {
    logic [7:0] pm;
    logic [7:0] reg_en;
    logic [3:0] src_sel;
    logic       alu_en;
    logic       jmp;
    logic       jmp_nz;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Control outputs implied by an instruction word, from the encoding table.
  function automatic void ref_ctrl(input logic [7:0] i, output logic [7:0] re,
                                   output logic [3:0] ss, output logic ae);
    int v;
    int d;
    int s;
    v  = int'(i);
    re = 8'h00;
    ss = 4'd0;
    ae = 1'b0;
    if (v < 128) begin
      re = 8'(1 << (v / 16));
      ss = 4'd8;
    end else if (v < 192) begin
      d = (v / 8) % 8;
      s = v % 8;
      if (d != s) begin
        re = 8'(1 << d);
        ss = 4'(s);
      end
    end else if (v < 224) begin
      ae = 1'b1;
      ss = 4'd9;
    end
  endfunction

  task automatic check_all(input string tag);
    logic [7:0] re;
    logic [3:0] ss;
    logic       ae;
    logic       running;
    int         pm;
    ref_ctrl(m_ir, re, ss, ae);
    running = (m_edges >= 2) && !reset;
    pm = int'(bus.pm_data);
    chk($sformatf("%s.sync_reset", tag), bus.sync_reset, !running);
    chk($sformatf("%s.jmp", tag), bus.jmp, running && pm >= 224 && pm < 240);
    chk($sformatf("%s.jmp_nz", tag), bus.jmp_nz, running && pm >= 240);
    chk($sformatf("%s.jmp_addr", tag), bus.jmp_addr, pm % 16);
    chk($sformatf("%s.dont_jmp", tag), bus.dont_jmp, m_flag);
    chk($sformatf("%s.ir", tag), bus.ir, m_ir);
    chk($sformatf("%s.reg_en", tag), bus.reg_en, re);
    chk($sformatf("%s.src_sel", tag), bus.src_sel, ss);
    chk($sformatf("%s.alu_en", tag), bus.alu_en, ae);
    chk($sformatf("%s.imm", tag), bus.imm, int'(m_ir) % 16);
    chk($sformatf("%s.alu_fn", tag), bus.alu_fn, int'(m_ir) % 8);
  endtask

  // One rising edge; the reference model advances from the pre-edge inputs.
  task automatic tick();
    logic [7:0] re;
    logic [3:0] ss;
    logic       ae;
    logic [7:0] pm_cap;
    logic       az_cap;
    ref_ctrl(m_ir, re, ss, ae);
    pm_cap = bus.pm_data;
    az_cap = bus.alu_zero;
    @(posedge clk);
    #1;
    if (reset) begin
      m_ir = 8'h80;
      m_flag = 1'b0;
      m_edges = 0;
    end else begin
      if (ae) m_flag = az_cap;
      m_ir = (m_edges < 2) ? 8'h80 : pm_cap;
      if (m_edges < 2) m_edges++;
    end
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    m_ir = 8'h80;
    m_flag = 1'b0;
    m_edges = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{8'h35, 8'b0000_1000, 4'd8, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'h7F, 8'b1000_0000, 4'd8, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{8'h00, 8'b0000_0001, 4'd8, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{8'h94, 8'b0000_0100, 4'd4, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{8'h9B, 8'b0000_0000, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{8'hBE, 8'b1000_0000, 4'd6, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{8'hC2, 8'b0000_0000, 4'd9, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{8'hD5, 8'b0000_0000, 4'd9, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{8'hE7, 8'b0000_0000, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{8'hF4, 8'b0000_0000, 4'd0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{8'h80, 8'b0000_0000, 4'd0, 1'b0, 1'b0, 1'b0};

    // Reset state, with a JNZ on the bus that must stay suppressed.
    bus.pm_data = 8'hF4;
    bus.alu_zero = 1'b0;
    #1;
    assert_reset();
    #1;
    chk("reset.sync_reset", bus.sync_reset, 1);
    chk("reset.ir", bus.ir, 8'h80);
    chk("reset.jmp_nz", bus.jmp_nz, 0);
    check_all("reset");
    tick();
    tick();
    check_all("reset_held");

    // Release: two edges of sync_reset, then the LOAD reaches ir one edge later.
    reset = 1'b0;
    bus.pm_data = 8'h35;
    #1;
    chk("release.sync_reset", bus.sync_reset, 1);
    tick();
    chk("edge1.sync_reset", bus.sync_reset, 1);
    tick();
    chk("edge2.sync_reset", bus.sync_reset, 0);
    chk("edge2.ir", bus.ir, 8'h80);
    tick();
    chk("load35.ir", bus.ir, 8'h35);
    chk("load35.reg_en", bus.reg_en, 8'b0000_1000);
    chk("load35.src_sel", bus.src_sel, 8);
    chk("load35.imm", bus.imm, 5);
    check_all("load35");

    // Table of single instructions: fetch-stage jumps, then execute decode.
    for (int k = 0; k < 11; k++) begin
      bus.pm_data = vecs[k].pm;
      #1;
      chk($sformatf("vec%0d.jmp", k), bus.jmp, vecs[k].jmp);
      chk($sformatf("vec%0d.jmp_nz", k), bus.jmp_nz, vecs[k].jmp_nz);
      chk($sformatf("vec%0d.jmp_addr", k), bus.jmp_addr, vecs[k].pm[3:0]);
      tick();
      chk($sformatf("vec%0d.ir", k), bus.ir, vecs[k].pm);
      chk($sformatf("vec%0d.reg_en", k), bus.reg_en, vecs[k].reg_en);
      chk($sformatf("vec%0d.src_sel", k), bus.src_sel, vecs[k].src_sel);
      chk($sformatf("vec%0d.alu_en", k), bus.alu_en, vecs[k].alu_en);
      check_all($sformatf("vec%0d", k));
    end

    // ALU sets the flag, JNZ fetched afterwards sees it; then the clear case.
    bus.alu_zero = 1'b0;
    bus.pm_data = 8'hC2;
    tick();
    bus.alu_zero = 1'b1;
    bus.pm_data = 8'h80;
    tick();
    bus.alu_zero = 1'b0;
    bus.pm_data = 8'hF4;
    #1;
    chk("jnz_set.jmp_nz", bus.jmp_nz, 1);
    chk("jnz_set.dont_jmp", bus.dont_jmp, 1);
    tick();
    bus.pm_data = 8'hC2;
    tick();
    bus.alu_zero = 1'b0;
    bus.pm_data = 8'h80;
    tick();
    bus.pm_data = 8'hF4;
    #1;
    chk("jnz_clr.jmp_nz", bus.jmp_nz, 1);
    chk("jnz_clr.dont_jmp", bus.dont_jmp, 0);
    tick();

    // Hazard: JNZ fetched while the ALU op is in ir sees the old flag.
    bus.pm_data = 8'hC2;
    tick();
    bus.alu_zero = 1'b1;
    bus.pm_data = 8'hF4;
    #1;
    chk("hazard.jmp_nz", bus.jmp_nz, 1);
    chk("hazard.dont_jmp_old", bus.dont_jmp, 0);
    tick();
    chk("hazard.dont_jmp_new", bus.dont_jmp, 1);
    chk("hazard.ir", bus.ir, 8'hF4);
    bus.alu_zero = 1'b0;

    // Mid-program reset between edges aborts the LOAD in ir.
    bus.pm_data = 8'h35;
    tick();
    chk("abort.pre_reg_en", bus.reg_en, 8'b0000_1000);
    chk("abort.pre_dont_jmp", bus.dont_jmp, 1);
    #2;
    assert_reset();
    #1;
    chk("abort.sync_reset", bus.sync_reset, 1);
    chk("abort.ir", bus.ir, 8'h80);
    chk("abort.dont_jmp", bus.dont_jmp, 0);
    chk("abort.reg_en", bus.reg_en, 0);
    check_all("abort");
    tick();
    reset = 1'b0;
    tick();
    tick();

    // Random instruction stream against the reference model, with rare resets.
    for (int n = 0; n < 300; n++) begin
      bus.pm_data = 8'($urandom);
      bus.alu_zero = 1'($urandom);
      if ($urandom_range(0, 39) == 0) assert_reset();
      #1;
      check_all($sformatf("rnd%0d.pre", n));
      tick();
      reset = 1'b0;
      check_all($sformatf("rnd%0d.post", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
